// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner selection for a shared DW-bit output mux.
// One owner at a time drives the path. Each tenure lasts at most MAX_HOLD
// cycles, and ownership hands over without an idle cycle. data_out/valid_out
// trail the grant by one registered stage.
// Optional feature: define ARB_LOCK_EN to add the `lock` input, which lets the
// current owner keep the path past MAX_HOLD for as long as it still requests.
module mux_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DW-1:0]       data_in,
`ifdef ARB_LOCK_EN
    input  logic                      lock,
`endif
    output logic [N_REQ-1:0]          grant,
    output logic [$clog2(N_REQ)-1:0]  sel,
    output logic [DW-1:0]             data_out,
    output logic                      valid_out
);

    localparam int SW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;
    logic [SW-1:0]   nxt;
    logic [SW-1:0]   start;
    logic [SW-1:0]   win_idx;
    logic            win_any;
    logic            own_req;
    logic            lock_on;
    logic            at_limit;
    logic            release_now;

`ifdef ARB_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    assign own_req  = req[sel];
    assign nxt      = (sel == SW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    // In IDLE the scan starts at ptr. On a release it starts just past the
    // owner, which is the same value ptr is updated to on that edge.
    assign start    = (state == IDLE) ? ptr : nxt;
    assign at_limit = (hold_cnt == HW'(MAX_HOLD - 1));
    // A locked owner that still requests never reaches the timeout.
    assign release_now = !own_req || (at_limit && !(lock_on && own_req));

    // First requester found scanning start, start+1, ... wrapping mod N_REQ.
    always_comb begin
        logic [SW-1:0] idx;
        win_any = 1'b0;
        win_idx = '0;
        idx     = '0;
        // Scan downwards so the entry closest to start is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = SW'((int'(start) + i) % N_REQ);
            if (req[idx]) begin
                win_any = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Arbitration FSM, tenure counter and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            sel       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (win_any) begin
                        grant    <= ONE << win_idx;
                        sel      <= win_idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // When the owner drops req, data_out keeps its last value
                    // and valid_out goes low.
                    valid_out <= own_req;
                    if (own_req)
                        data_out <= data_in[int'(sel)*DW +: DW];
                    if (!release_now) begin
                        // A locked owner parks the counter at the limit.
                        if (!at_limit)
                            hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        ptr      <= nxt;
                        hold_cnt <= '0;
                        if (win_any) begin
                            grant <= ONE << win_idx;
                            sel   <= win_idx;
                        end else begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
